// File: rtl/axi_write_pkg.sv
// Shared types and constants for the AXI write block: FSM encoding, bus word
// geometry and the last-beat strobe lookup.
package axi_write_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_FETCH,
    ST_LOAD,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } state_e;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] STRB_FULL  = 4'hF;

  // Strobe for the final beat, from the byte count modulo the word size.
  function automatic logic [3:0] last_strb(input logic [1:0] rem);
    case (rem)
      2'd1:    return 4'h1;
      2'd2:    return 4'h3;
      2'd3:    return 4'h7;
      default: return STRB_FULL;
    endcase
  endfunction

endpackage

// File: rtl/axi_write_block.sv
// Single-burst AXI write master: one address handshake, then one W beat per
// FIFO word, then wait for the write response. All bus outputs are flops.
module axi_write_block
  import axi_write_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [15:0] transfer_size,
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic        wvalid,
  output logic [3:0]  wstrb,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  input  logic [31:0] data_in,
  input  logic        empty,
  output logic        rd_en,
  output logic        busy,
  output logic        done
);

  state_e      state_q, state_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  size_rem_q, size_rem_d;
  logic [16:0] beats_q, beats_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        rd_en_q, rd_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [16:0] beats_calc;

  // Round the byte count up to whole 32-bit words without overflowing.
  assign beats_calc = ({1'b0, transfer_size} + 17'd3) >> 2;

  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    size_rem_d = size_rem_q;
    beats_d    = beats_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          awaddr_d   = addr;
          size_rem_d = transfer_size[1:0];
          beats_d    = beats_calc;
          state_d    = (transfer_size == 16'd0) ? ST_DONE : ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (awready) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (!empty) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        // First LOAD cycle carries the rd_en pulse; data_in is valid on the next.
        if (!rd_en_q) begin
          wdata_d = data_in;
          wstrb_d = (beats_q == 17'd1) ? last_strb(size_rem_q) : STRB_FULL;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (wready) begin
          beats_d = beats_q - 17'd1;
          state_d = (beats_q == 17'd1) ? ST_RESP : ST_FETCH;
        end
      end
      ST_RESP: begin
        if (bvalid) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they come straight from flops.
    awvalid_d = (state_d == ST_ADDR);
    wvalid_d  = (state_d == ST_DATA);
    bready_d  = (state_d == ST_RESP);
    rd_en_d   = (state_q == ST_FETCH) && (state_d == ST_LOAD);
    busy_d    = (state_d inside {ST_ADDR, ST_FETCH, ST_LOAD, ST_DATA, ST_RESP});
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      size_rem_q <= '0;
      beats_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      size_rem_q <= size_rem_d;
      beats_q    <= beats_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign awaddr  = awaddr_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wvalid  = wvalid_q;
  assign wstrb   = wstrb_q;
  assign bready  = bready_q;
  assign rd_en   = rd_en_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_axi_write_block.sv
// Bench for axi_write_block: FIFO and AXI slave models with stall control,
// scoreboarded AW/W payloads, a transfer table and a few corner sequences.
module tb_axi_write_block;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] addr;
  logic [15:0] transfer_size;
  logic [31:0] awaddr, wdata, data_in;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic        empty, rd_en, busy, done;

  axi_write_block dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr),
    .transfer_size(transfer_size), .awaddr(awaddr), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wvalid(wvalid), .wstrb(wstrb),
    .wready(wready), .bvalid(bvalid), .bready(bready), .data_in(data_in),
    .empty(empty), .rd_en(rd_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] size;
    int          aw_st;
    int          w_st;
    int          b_st;
    int          beats;
    logic [3:0]  last_strb;
    bit          fixed;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] fixed_words[4];
  logic [31:0] fifo_q[$];
  logic [31:0] hold_q[$];
  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];

  int n_pass = 0, n_total = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, done_rises = 0;
  int aw_stall = 0, w_stall = 0, b_stall = 0;

  // responder state
  logic [31:0] pending;
  bit          load_next;
  int          aw_cnt, w_cnt, b_cnt;
  bit          aw_wait, w_wait, b_wait, done_prev;
  logic [31:0] aw_saved;
  logic [35:0] w_saved;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // FIFO + AXI slave model, evaluated at the falling edge for the next rising edge.
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; empty = 1'b1; data_in = '0;
    load_next = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; done_prev = 0;
    aw_saved = '0; w_saved = '0; pending = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; load_next = 0;
      end
      if (aw_wait) check("aw_hold", 64'({awvalid, awaddr}), 64'({1'b1, aw_saved}));
      if (w_wait)  check("w_hold", 64'({wvalid, wdata, wstrb}), 64'({1'b1, w_saved}));
      if (b_wait)  check("b_hold", 64'(bready), 64'(1));
      check("excl", 64'(($countones({awvalid, wvalid, bready, rd_en}) <= 1) && !(busy && done)), 64'(1));

      if (load_next) begin
        data_in = pending;
        load_next = 0;
      end else begin
        data_in = $urandom;
      end
      if (rd_en) begin
        check("rd_en_nonempty", 64'(fifo_q.size() != 0), 64'(1));
        if (fifo_q.size() != 0) begin
          pending = fifo_q.pop_front();
          load_next = 1;
        end
      end
      empty = (fifo_q.size() == 0);

      if (awvalid && aw_cnt >= aw_stall) awready = 1'b1;
      else begin awready = 1'b0; if (awvalid) aw_cnt++; end
      if (wvalid && w_cnt >= w_stall) wready = 1'b1;
      else begin wready = 1'b0; if (wvalid) w_cnt++; end
      if (bready && b_cnt >= b_stall) bvalid = 1'b1;
      else begin bvalid = 1'b0; if (bready) b_cnt++; end

      if (awvalid && awready) begin
        aw_hs++; aw_cnt = 0;
        check("aw_expected", 64'(exp_aw.size() != 0), 64'(1));
        if (exp_aw.size() != 0) check("awaddr", 64'(awaddr), 64'(exp_aw.pop_front()));
      end
      if (wvalid && wready) begin
        w_hs++; w_cnt = 0;
        check("w_expected", 64'(exp_w.size() != 0), 64'(1));
        if (exp_w.size() != 0) check("wdata_wstrb", 64'({wdata, wstrb}), 64'(exp_w.pop_front()));
      end
      if (bready && bvalid) begin
        b_hs++; b_cnt = 0;
      end

      aw_wait = awvalid && !awready; aw_saved = awaddr;
      w_wait  = wvalid && !wready;   w_saved  = {wdata, wstrb};
      b_wait  = bready && !bvalid;
      if (done && !done_prev) done_rises++;
      done_prev = done;
    end
  end

  task automatic setup(input vec_t v, input int prefill);
    logic [31:0] word;
    aw_stall = v.aw_st; w_stall = v.w_st; b_stall = v.b_st;
    for (int i = 0; i < v.beats; i++) begin
      word = v.fixed ? fixed_words[i % 4] : $urandom;
      if (i < prefill) fifo_q.push_back(word);
      else hold_q.push_back(word);
      exp_w.push_back({word, (i == v.beats - 1) ? v.last_strb : 4'hF});
    end
    if (v.beats > 0) exp_aw.push_back(v.addr);
  endtask

  task automatic kick(input vec_t v);
    @(negedge clk);
    start = 1'b1; addr = v.addr; transfer_size = v.size;
    @(negedge clk);
    start = 1'b0;
    if (v.beats == 0) begin
      check("zero_done", 64'({done, busy, awvalid}), 64'(3'b100));
    end else begin
      check("start_busy", 64'({busy, done, awvalid}), 64'(3'b101));
    end
  endtask

  task automatic wait_done(input vec_t v, input int aw0);
    int budget;
    int c;
    budget = 200 + v.beats * (v.w_st + 8) + v.aw_st + v.b_st;
    c = 0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_seen", 64'(done), 64'(1));
    check("done_not_busy", 64'(busy), 64'(0));
    check("aw_count", 64'(aw_hs - aw0), 64'((v.beats > 0) ? 1 : 0));
    check("w_remaining", 64'(exp_w.size()), 64'(0));
    check("fifo_remaining", 64'(fifo_q.size() + hold_q.size()), 64'(0));
    $display("xfer addr=%08h size=%0d beats=%0d cycles=%0d", v.addr, v.size, v.beats, c);
  endtask

  initial begin
    vec_t v;
    int   aw0, w0, d0, c;
    reset = 1'b1; start = 1'b0; addr = '0; transfer_size = '0;
    fixed_words = '{32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5, 32'h00000000};
    vecs[0] = '{32'h00001000, 16'd16,   0, 0, 0, 4,   4'hF, 1'b1};
    vecs[1] = '{32'h00002004, 16'd6,    3, 3, 3, 2,   4'h3, 1'b0};
    vecs[2] = '{32'h00003001, 16'd1,    0, 1, 0, 1,   4'h1, 1'b0};
    vecs[3] = '{32'h00004000, 16'd7,    1, 0, 2, 2,   4'h7, 1'b0};
    vecs[4] = '{32'h00005000, 16'd9,    0, 2, 1, 3,   4'h1, 1'b0};
    vecs[5] = '{32'h00006000, 16'd0,    0, 0, 0, 0,   4'hF, 1'b0};
    vecs[6] = '{32'hFFFFFFF0, 16'd1027, 0, 0, 0, 257, 4'h7, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_valids", 64'({awvalid, wvalid, bready, rd_en}), 64'(0));
    check("rst_status", 64'({busy, done}), 64'(0));
    check("rst_awaddr", 64'(awaddr), 64'(0));
    check("rst_wdata", 64'(wdata), 64'(0));
    check("rst_wstrb", 64'(wstrb), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      aw0 = aw_hs;
      setup(vecs[i], vecs[i].beats);
      kick(vecs[i]);
      if (vecs[i].beats == 0) begin
        repeat (3) begin
          @(negedge clk);
          check("zero_quiet", 64'({awvalid, wvalid, rd_en}), 64'(0));
        end
      end
      wait_done(vecs[i], aw0);
    end

    // FIFO runs dry after the first word: no pop and no W valid while empty.
    v = '{32'h00007000, 16'd8, 0, 0, 0, 2, 4'hF, 1'b0};
    aw0 = aw_hs; w0 = w_hs;
    setup(v, 1);
    kick(v);
    c = 0;
    while (w_hs == w0 && c < 60) begin @(negedge clk); c++; end
    check("first_beat", 64'(w_hs - w0), 64'(1));
    repeat (5) begin
      @(negedge clk);
      check("empty_stall", 64'({rd_en, wvalid}), 64'(0));
    end
    fifo_q.push_back(hold_q.pop_front());
    wait_done(v, aw0);

    // Reset in the middle of a stalled W beat.
    v = '{32'h00008000, 16'd8, 0, 20, 0, 2, 4'hF, 1'b0};
    setup(v, 2);
    kick(v);
    c = 0;
    while (!wvalid && c < 60) begin @(negedge clk); c++; end
    check("reach_data", 64'(wvalid), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valids", 64'({awvalid, wvalid, bready, rd_en, busy, done}), 64'(0));
    check("midrst_regs", 64'({awaddr, wstrb}), 64'(0));
    check("midrst_wdata", 64'(wdata), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    fifo_q.delete(); hold_q.delete(); exp_w.delete(); exp_aw.delete();
    aw0 = aw_hs; w0 = w_hs;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_quiet", 64'({awvalid, wvalid, bready, rd_en, busy, done}), 64'(0));
    end
    check("post_rst_hs", 64'((w_hs - w0) + (aw_hs - aw0)), 64'(0));
    v = '{32'h00009000, 16'd4, 0, 0, 0, 1, 4'hF, 1'b0};
    aw0 = aw_hs;
    setup(v, 1);
    kick(v);
    wait_done(v, aw0);

    // A start pulse during RESP must be dropped.
    v = '{32'h0000A000, 16'd4, 0, 0, 4, 1, 4'hF, 1'b0};
    aw0 = aw_hs; d0 = done_rises;
    setup(v, 1);
    kick(v);
    c = 0;
    while (!bready && c < 60) begin @(negedge clk); c++; end
    check("reach_resp", 64'(bready), 64'(1));
    start = 1'b1; addr = 32'h0000BAD0; transfer_size = 16'd8;
    @(negedge clk);
    start = 1'b0;
    wait_done(v, aw0);
    check("single_done", 64'(done_rises - d0), 64'(1));
    repeat (3) @(negedge clk);
    check("stay_done", 64'({done, busy, awvalid}), 64'(3'b100));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_write_block.md
AXI_WRITE_BLOCK -- requirements
Module: axi_write_block

Interface
REQ-001 clk  input  1  single clock; all logic on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 start  input  1  one-cycle request to begin a transfer; ignored while busy.
REQ-004 addr  input  32  destination byte address, sampled on accepted start.
REQ-005 transfer_size  input  16  transfer length in bytes, sampled on accepted start.
REQ-006 awaddr  output  32  write address; equals sampled addr.
REQ-007 awvalid  output  1  address valid.
REQ-008 awready  input  1  address ready.
REQ-009 wdata  output  32  write data.
REQ-010 wvalid  output  1  data valid.
REQ-011 wstrb  output  4  byte strobes.
REQ-012 wready  input  1  data ready.
REQ-013 bvalid  input  1  write response valid.
REQ-014 bready  output  1  write response ready.
REQ-015 data_in  input  32  FIFO read data, valid the cycle after rd_en.
REQ-016 empty  input  1  FIFO empty flag.
REQ-017 rd_en  output  1  FIFO pop, one-cycle pulse per word.
REQ-018 busy  output  1  transfer in progress.
REQ-019 done  output  1  transfer complete, held until next accepted start.

Function
REQ-020 FSM states: IDLE, ADDR, FETCH, LOAD, DATA, RESP, DONE.
REQ-021 IDLE/DONE + start: latch addr, transfer_size; beats = (transfer_size+3)>>2 (17-bit arithmetic); clear done; set busy; go ADDR.
REQ-022 transfer_size = 0 on accepted start: no bus activity, go directly to DONE in the next cycle.
REQ-023 ADDR: awvalid=1, awaddr=latched addr, held stable until awready; on handshake go FETCH.
REQ-024 Exactly one address handshake per transfer; the address does not increment.
REQ-025 FETCH: if !empty, pulse rd_en for one cycle and go LOAD; if empty, stall with rd_en=0.
REQ-026 LOAD: capture data_in into wdata register; go DATA.
REQ-027 DATA: wvalid=1; wdata and wstrb held stable until wready; on handshake decrement the remaining-beat counter.
REQ-028 After a DATA handshake, go FETCH if beats remain, else go RESP.
REQ-029 wstrb = 4'hF on every beat except the last.
REQ-030 Last beat wstrb: transfer_size[1:0] = 1/2/3 gives 4'h1/4'h3/4'h7; 0 gives 4'hF.
REQ-031 RESP: bready=1 until bvalid; on handshake go DONE. bresp is not checked.
REQ-032 DONE: done=1, busy=0; stay until the next start.
REQ-033 busy=1 in ADDR..RESP inclusive; done and busy are never high together.
REQ-034 awvalid, wvalid, bready and rd_en are mutually exclusive and registered (no combinational path from ready inputs).
REQ-035 start while busy is ignored; no queuing.

Reset
REQ-036 reset (sync) gives state IDLE; awvalid=wvalid=bready=rd_en=busy=done=0; awaddr=wdata=0; wstrb=0; counters 0.
REQ-037 reset mid-transfer aborts immediately: no further handshakes, no rd_en, done stays 0.

Structure
REQ-038 Shared package axi_write_pkg holds the FSM state enum, WORD_BYTES=4 and STRB_FULL=4'hF.
REQ-039 Single flat module; no sub-modules.

Verification
REQ-040 addr=0x1000, size=16, FIFO = DEADBEEF, 12345678, A5A5A5A5, 00000000, readies all 1 -> one AW with awaddr=0x1000, 4 W beats in FIFO order, wstrb=F, then done=1 and busy=0.
REQ-041 size=6, readies stalled 3 cycles each -> 2 beats with wstrb F then 3; valid signals and payloads held stable during each stall.
REQ-042 empty=1 for 5 cycles during FETCH -> rd_en=0 and wvalid=0 throughout; the transfer resumes when empty falls, and data is neither lost nor duplicated.
REQ-043 size=0 -> no awvalid or wvalid; done=1 within 2 cycles.
REQ-044 reset asserted during DATA -> all outputs 0 the next cycle; a fresh start (size=4) completes normally.
REQ-045 start pulsed during RESP -> ignored; the original transfer completes with a single done.
